// File: rtl/serializador_pkg.sv
// Shared types and constants for the serializer transmitter.
package serializador_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } state_t;

endpackage

// File: rtl/contador_bits.sv
// Bit counter for the serializer: synchronous clear has priority over count enable.
module contador_bits #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/serializador_tx.sv
// MSB-first parallel-to-serial transmitter with optional even-parity bit.
// All outputs are decoded from registered state only.
module serializador_tx
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter bit          PAR_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             load,
  output logic             ready,
  output logic             Dout_serie,
  output logic             SEL,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_shreg;
  logic             r_par;
  logic [CNT_W-1:0] w_count;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && load;
  assign w_last   = (w_count == CNT_W'(WIDTH - 1));

  contador_bits #(
    .CNT_W (CNT_W)
  ) u_contador_bits (
    .clk     (clk),
    .i_clr   (reset | w_accept),
    .i_en    (r_state == SHIFT),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_shreg <= Din;
        // Parity is taken at capture because the shift register empties as it shifts.
        r_par   <= ^Din;
      end else if (r_state == SHIFT) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    ready      = 1'b0;
    SEL        = 1'b0;
    Dout_serie = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (load) w_state_d = SHIFT;
      end
      SHIFT: begin
        SEL        = 1'b1;
        Dout_serie = r_shreg[WIDTH-1];
        if (w_last) w_state_d = PAR_EN ? PARITY : DONE;
      end
      PARITY: begin
        SEL        = 1'b1;
        Dout_serie = r_par;
        w_state_d  = DONE;
      end
      DONE: begin
        done      = 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serializador_tx.sv
// Directed bench for serializador_tx: one instance without parity, one with.
module tb_serializador_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       load_p;
  logic [3:0] din;

  logic ready0, sel0, dout0, done0;
  logic ready1, sel1, dout1, done1;

  logic [3:0] lb = '0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serializador_tx #(
    .WIDTH  (4),
    .PAR_EN (1'b0)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .Din        (din),
    .load       (load),
    .ready      (ready0),
    .Dout_serie (dout0),
    .SEL        (sel0),
    .done       (done0)
  );

  serializador_tx #(
    .WIDTH  (4),
    .PAR_EN (1'b1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .Din        (din),
    .load       (load_p),
    .ready      (ready1),
    .Dout_serie (dout1),
    .SEL        (sel1),
    .done       (done1)
  );

  // Downstream MSB-first serial-in register enabled by SEL.
  always @(posedge clk) begin
    if (sel0) lb <= {lb[2:0], dout0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Output vector order: {ready, SEL, Dout_serie, done}
  task automatic chk0(input string tag, input logic [3:0] exp);
    chk(tag, {ready0, sel0, dout0, done0}, exp);
  endtask

  task automatic chk1(input string tag, input logic [3:0] exp);
    chk(tag, {ready1, sel1, dout1, done1}, exp);
  endtask

  // Checks the four data-bit cycles; returns in the cycle after the last bit.
  task automatic bits0(input string tag, input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      chk0($sformatf("%s_b%0d", tag, i), {2'b01, w[3-i], 1'b0});
      tick();
    end
  endtask

  task automatic bits1(input string tag, input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("%s_b%0d", tag, i), {2'b01, w[3-i], 1'b0});
      tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    load_p = 1'b0;
    din    = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    chk0("rst_dut0", 4'b1000);
    chk1("rst_dut1", 4'b1000);

    // Basic frame, first edge after reset; Din scrambled after acceptance.
    load = 1'b1;
    din  = 4'b1011;
    tick();
    load = 1'b0;
    din  = 4'b0000;
    bits0("basic", 4'b1011);
    chk0("basic_done", 4'b0001);
    chk("basic_lb", lb, 4'b1011);
    chk1("basic_dut1_idle", 4'b1000);
    tick();
    chk0("basic_ready", 4'b1000);

    // Parity frame, odd word: parity bit 1.
    load_p = 1'b1;
    din    = 4'b1011;
    tick();
    load_p = 1'b0;
    din    = 4'b0100;
    bits1("par1", 4'b1011);
    chk1("par1_pbit", 4'b0110);
    tick();
    chk1("par1_done", 4'b0001);
    tick();
    chk1("par1_ready", 4'b1000);

    // Parity frame, even word: parity bit 0.
    load_p = 1'b1;
    din    = 4'b0110;
    tick();
    load_p = 1'b0;
    bits1("par0", 4'b0110);
    chk1("par0_pbit", 4'b0100);
    tick();
    chk1("par0_done", 4'b0001);
    tick();
    chk1("par0_ready", 4'b1000);

    // Loopback into the serial-in register.
    load = 1'b1;
    din  = 4'b0110;
    tick();
    load = 1'b0;
    bits0("lpbk", 4'b0110);
    chk0("lpbk_done", 4'b0001);
    chk("lpbk_reg", lb, 4'b0110);
    tick();

    // Load during a frame is ignored and not queued.
    load = 1'b1;
    din  = 4'b1011;
    tick();
    load = 1'b0;
    chk0("ign_b0", 4'b0110);
    tick();
    load = 1'b1;
    din  = 4'b0001;
    chk0("ign_b1", 4'b0100);
    tick();
    load = 1'b0;
    chk0("ign_b2", 4'b0110);
    tick();
    chk0("ign_b3", 4'b0110);
    tick();
    chk0("ign_done", 4'b0001);
    tick();
    chk0("ign_ready", 4'b1000);
    tick();
    chk0("ign_noframe", 4'b1000);

    // Reset in cycle 3 aborts both frames with no done pulse.
    load   = 1'b1;
    load_p = 1'b1;
    din    = 4'b1011;
    tick();
    load   = 1'b0;
    load_p = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk0("abort_idle0", 4'b1000);
    chk1("abort_idle1", 4'b1000);
    load = 1'b1;
    din  = 4'b1010;
    tick();
    load = 1'b0;
    chk1("abort_nodone1", 4'b1000);
    bits0("clean", 4'b1010);
    chk0("clean_done", 4'b0001);
    tick();
    chk0("clean_ready", 4'b1000);

    // Reset wins over a simultaneous load.
    reset = 1'b1;
    load  = 1'b1;
    din   = 4'b1111;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    chk0("prio_idle", 4'b1000);
    tick();
    chk0("prio_noframe", 4'b1000);

    // Back-to-back frames at minimum spacing.
    load = 1'b1;
    din  = 4'b1100;
    tick();
    load = 1'b0;
    bits0("b2b_a", 4'b1100);
    chk0("b2b_a_done", 4'b0001);
    tick();
    chk0("b2b_a_ready", 4'b1000);
    load = 1'b1;
    din  = 4'b0011;
    tick();
    load = 1'b0;
    bits0("b2b_b", 4'b0011);
    chk0("b2b_b_done", 4'b0001);
    tick();
    chk0("b2b_b_ready", 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serializador_tx.md
SERIALIZADOR_TX -- requirements
Module: serializador_tx

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits; legal range 2..16.
REQ-002 Parameter PAR_EN, default 0: 1 appends an even-parity bit after the data bits; 0 sends no parity bit.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Din  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-006 load  input  1  transmit request; accepted when load=1 and ready=1 on the same posedge.
REQ-007 ready  output  1  high when a new word can be accepted.
REQ-008 Dout_serie  output  1  serial data, MSB first.
REQ-009 SEL  output  1  high exactly while Dout_serie carries a valid bit; intended to drive a downstream shift register's serial-enable.
REQ-010 done  output  1  one-cycle pulse after the final bit.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, PARITY and DONE.
REQ-012 All outputs SHALL be Moore outputs, decoded from registered state and the shift register only; no combinational path from any input to any output.
REQ-013 IDLE outputs SHALL be ready=1, SEL=0, Dout_serie=0, done=0.
REQ-014 IDLE transition: on an accepted load, capture Din into the shift register, clear the bit counter, and enter SHIFT at the next edge.
REQ-015 SHIFT outputs SHALL be SEL=1, Dout_serie=shreg[WIDTH-1], ready=0.
REQ-016 SHIFT advance: each edge shifts shreg left with 0 fill and increments the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles.
REQ-018 SHIFT exit: go to PARITY if PAR_EN=1, else to DONE.
REQ-019 PARITY SHALL last one cycle, with SEL=1 and Dout_serie = XOR of the captured word; then go to DONE.
REQ-020 DONE SHALL last one cycle, with done=1, SEL=0, ready=0, Dout_serie=0; then go to IDLE.
REQ-021 Latency for a load accepted at edge N, with PAR_EN=0: bit i (MSB=i=0) is on Dout_serie in cycle N+1+i; done in cycle N+WIDTH+1; ready in cycle N+WIDTH+2.
REQ-022 With PAR_EN=1, the done and ready timings SHALL each be one cycle later than in REQ-021.
REQ-023 load while ready=0 SHALL be ignored and not queued.
REQ-024 Changes on Din after acceptance SHALL NOT affect the word in flight.
REQ-025 Minimum load-to-load spacing SHALL be WIDTH+2 cycles (WIDTH+3 with PAR_EN=1).
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-027 reset=1 SHALL force IDLE and clear shreg and the counter to 0.
REQ-028 After reset, outputs SHALL be ready=1, SEL=0, Dout_serie=0, done=0 from the cycle following the reset edge.
REQ-029 reset SHALL take priority over load on the same edge.
REQ-030 reset during SHIFT or PARITY SHALL abort the frame with no done pulse.
REQ-031 A load on the first edge with reset=0 after reset SHALL be accepted.

Structure
REQ-032 Package serializador_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY, DONE) and the default-width constant.
REQ-033 The bit counter SHALL be the single sub-module, contador_bits: clear, enable and count output.
REQ-034 Everything else SHALL live in serializador_tx.

Verification
REQ-035 WIDTH=4, PAR_EN=0, Din=1011, load at cycle 0 -> Dout_serie 1,0,1,1 with SEL=1 in cycles 1-4; done=1 in cycle 5; ready=1 in cycle 6.
REQ-036 PAR_EN=1, Din=1011 -> 1,0,1,1 then parity bit 1 in cycle 5 with SEL=1; done in cycle 6.
REQ-037 Loopback: Dout_serie/SEL drive a 4-bit MSB-first serial-in register, Din=0110 -> register reads 0110 during the done cycle.
REQ-038 load pulsed in cycle 2 of a frame with Din=0001 -> ignored; the frame in flight is unchanged; no second frame starts.
REQ-039 reset asserted in cycle 3 of a frame -> IDLE next cycle, SEL=0, no done pulse; load in the following cycle starts a clean frame.
REQ-040 Back-to-back loads 1100 then 0011, each issued as soon as ready=1 -> two contiguous frames 1,1,0,0 and 0,0,1,1, separated only by the done cycle and the idle cycle.
